id_hazard_ctrl: RTL and testbench
=================================

// Module: id_hazard_ctrl
// PURPOSE
//  Issue controller for the decode stage. A per-register scoreboard tracks destinations of issued,
//  unretired instructions and stalls the ID instruction on RAW/WAW hazards, EX back-pressure or redirect.
//  Sits beside id_top; drives the ID/EX pipeline-register enable and bubble insert. Counts stall cycles.
// PARAMETERS
//  WB_BYPASS  1   1: writeback clearing a reg in the same cycle resolves hazard (regfile write-before-read)
//  CNT_W      32  width of saturating stall-cycle counter
// PORTS
//  i_clk       in   1   clock, rising edge
//  i_reset_n   in   1   reset, synchronous, active-low
//  i_idValid   in   1   ID holds a valid decoded instruction
//  i_rs1       in   5   source reg 1 index
//  i_rs2       in   5   source reg 2 index
//  i_rs1Used   in   1   instruction reads rs1
//  i_rs2Used   in   1   instruction reads rs2
//  i_rd        in   5   destination reg index
//  i_regWrite  in   1   instruction writes rd
//  i_exReady   in   1   EX can accept an instruction this cycle
//  i_flush     in   1   branch/jump redirect from EX (1-cycle pulse)
//  i_wbValid   in   1   writeback retires a register write this cycle
//  i_wbReg     in   5   writeback destination index
//  o_issue     out  1   ID instruction advances to EX this cycle
//  o_stall     out  1   hold IF/ID registers
//  o_bubble    out  1   load NOP into ID/EX register
//  o_kill      out  1   invalidate IF/ID contents (wrong path)
//  o_pending   out  32  scoreboard; bit n = reg n awaiting writeback
//  o_stallCnt  out  CNT_W  stall cycles since reset, saturates at all-ones
// BEHAVIOUR
//  - Reset (i_reset_n=0 at edge): state=RUN, o_pending=0, o_stallCnt=0; outputs combinational from these.
//  - clr = i_wbValid & i_wbReg!=0; pend_eff = o_pending & ~(WB_BYPASS&clr ? 1<<i_wbReg : 0).
//  - hazard = (i_rs1Used & pend_eff[i_rs1]) | (i_rs2Used & pend_eff[i_rs2]) | (i_regWrite & pend_eff[i_rd]);
//    index 0 never hazards; bit 0 of o_pending is constant 0.
//  - o_issue = i_idValid & ~hazard & i_exReady & ~i_flush & state!=FLUSH.
//  - o_stall = i_idValid & ~o_issue & ~i_flush & state!=FLUSH.
//  - o_bubble = ~o_issue (EX gets NOP whenever nothing issues, incl. flush).
//  - o_kill = i_flush | state==FLUSH.
//  - Scoreboard update at edge: clear bit i_wbReg if clr; set bit i_rd if o_issue & i_regWrite & i_rd!=0;
//    set and clear of the same bit in one cycle -> set wins. Clear of a non-pending bit is ignored.
//  - FSM: RUN -> HOLD when o_stall; HOLD -> RUN when o_issue or ~i_idValid; any state -> FLUSH on i_flush;
//    FLUSH -> RUN next cycle (one extra kill cycle drops the IF-stage wrong-path instr). i_flush while
//    in FLUSH restarts FLUSH. HOLD/RUN differ only for the counter; issue logic identical.
//  - o_stallCnt += 1 each cycle o_stall=1; holds at 2^CNT_W-1.
//  - Latency: hazard->stall combinational (0 cycles); retirement frees consumer same cycle if WB_BYPASS=1,
//    else next cycle.
//  - Reset mid-stall/mid-flush: all state cleared, no pending bits survive.
// STRUCTURE
//  - id_pkg: typedef logic [4:0] reg_idx_t; enum {RUN, HOLD, FLUSH} hz_state_t; localparam NUM_REGS=32.
//  - Sub-module id_scoreboard: 32-bit pending vector, set/clear ports, two read ports + rd check port,
//    bypass mask; id_hazard_ctrl holds FSM, issue logic, counter.
// TESTING
//  - Reset: hold i_reset_n=0 two cycles -> o_pending=0, o_stallCnt=0, o_kill=0, o_issue follows i_idValid.
//  - RAW: issue rd=5 regWrite; next instr rs1=5 -> o_stall=1, o_bubble=1 until i_wbValid,i_wbReg=5;
//    WB_BYPASS=1: issue same cycle; =0: next cycle; o_stallCnt matches stall cycles.
//  - x0: issue rd=0 regWrite, then rs1=0 -> no stall, o_pending[0]=0.
//  - Same-cycle set/clear: wb retires r7 while new instr with rd=7 issues -> o_pending[7]=1 after edge.
//  - Flush: i_flush during RAW stall -> o_issue=0, o_kill=1 two cycles (flush + FLUSH), back to RUN;
//    o_pending unchanged except wb clears.
//  - Back-pressure: i_exReady=0, no hazard -> o_stall=1, no pending set; i_exReady=1 -> single issue.

Source files
------------

// File: rtl/id_pkg.sv
// Shared types and helpers for the decode-stage issue controller.
package id_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

  // One-hot register mask; x0 never produces a bit, so it can never be pending.
  function automatic logic [NUM_REGS-1:0] idx_mask(input reg_idx_t idx, input logic en);
    logic [NUM_REGS-1:0] one_s;
    one_s = {{(NUM_REGS-1){1'b0}}, 1'b1};
    if (en && (idx != 5'd0)) begin
      idx_mask = one_s << idx;
    end else begin
      idx_mask = {NUM_REGS{1'b0}};
    end
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Pending-writeback scoreboard: one bit per architectural register.
// Reads see the writeback clear of the current cycle when WB_BYPASS is set.
module id_scoreboard
  import id_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_setEn,
  input  reg_idx_t            i_setIdx,
  input  logic                i_clrEn,
  input  reg_idx_t            i_clrIdx,
  input  reg_idx_t            i_rs1,
  input  reg_idx_t            i_rs2,
  input  reg_idx_t            i_rd,
  output logic [NUM_REGS-1:0] o_pending,
  output logic                o_rs1Pend,
  output logic                o_rs2Pend,
  output logic                o_rdPend
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] eff_s;

  // Next pending vector (set beats clear on the same bit) and bypassed read view.
  always_comb begin
    set_mask_s = idx_mask(i_setIdx, i_setEn);
    clr_mask_s = idx_mask(i_clrIdx, i_clrEn);
    pend_d     = (pend_q & ~clr_mask_s) | set_mask_s;
    pend_d[0]  = 1'b0;
    if (WB_BYPASS) begin
      eff_s = pend_q & ~clr_mask_s;
    end else begin
      eff_s = pend_q;
    end
    o_rs1Pend = eff_s[i_rs1];
    o_rs2Pend = eff_s[i_rs2];
    o_rdPend  = eff_s[i_rd];
  end

  // Pending-vector register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pend_q <= {NUM_REGS{1'b0}};
    end else begin
      pend_q <= pend_d;
    end
  end

  assign o_pending = pend_q;

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage issue controller: hazard detection against the scoreboard,
// issue/stall/bubble/kill generation, redirect FSM and saturating stall counter.
module id_hazard_ctrl
  import id_pkg::*;
#(
  parameter bit          WB_BYPASS = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_idValid,
  input  reg_idx_t            i_rs1,
  input  reg_idx_t            i_rs2,
  input  logic                i_rs1Used,
  input  logic                i_rs2Used,
  input  reg_idx_t            i_rd,
  input  logic                i_regWrite,
  input  logic                i_exReady,
  input  logic                i_flush,
  input  logic                i_wbValid,
  input  reg_idx_t            i_wbReg,
  output logic                o_issue,
  output logic                o_stall,
  output logic                o_bubble,
  output logic                o_kill,
  output logic [NUM_REGS-1:0] o_pending,
  output logic [CNT_W-1:0]    o_stallCnt
);

  hz_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rs1_pend_s;
  logic             rs2_pend_s;
  logic             rd_pend_s;
  logic             hazard_s;
  logic             in_flush_s;
  logic             issue_s;
  logic             stall_s;

  id_scoreboard #(
    .WB_BYPASS (WB_BYPASS)
  ) u_sb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_setEn   (issue_s & i_regWrite),
    .i_setIdx  (i_rd),
    .i_clrEn   (i_wbValid),
    .i_clrIdx  (i_wbReg),
    .i_rs1     (i_rs1),
    .i_rs2     (i_rs2),
    .i_rd      (i_rd),
    .o_pending (o_pending),
    .o_rs1Pend (rs1_pend_s),
    .o_rs2Pend (rs2_pend_s),
    .o_rdPend  (rd_pend_s)
  );

  // Hazard and issue decisions; same-cycle so a hazard stalls with no latency.
  always_comb begin
    in_flush_s = (state_q == FLUSH);
    hazard_s   = (i_rs1Used & rs1_pend_s) | (i_rs2Used & rs2_pend_s) | (i_regWrite & rd_pend_s);
    issue_s    = i_idValid & ~hazard_s & i_exReady & ~i_flush & ~in_flush_s;
    stall_s    = i_idValid & ~issue_s & ~i_flush & ~in_flush_s;
  end

  assign o_issue    = issue_s;
  assign o_stall    = stall_s;
  assign o_bubble   = ~issue_s;
  assign o_kill     = i_flush | in_flush_s;
  assign o_stallCnt = cnt_q;

  // Redirect/hold FSM and saturating stall-cycle counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= RUN;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= cnt_q;
      end
      if (i_flush) begin
        state_q <= FLUSH;
      end else begin
        case (state_q)
          RUN:     state_q <= stall_s ? HOLD : RUN;
          HOLD:    state_q <= (issue_s || !i_idValid) ? RUN : HOLD;
          FLUSH:   state_q <= RUN;
          default: state_q <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed table-driven bench for id_hazard_ctrl plus multi-cycle corner sequences.
module tb_id_hazard_ctrl;

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        w;
    logic        rdy;
    logic        fl;
    logic        wbv;
    logic [4:0]  wbr;
    logic [3:0]  exp_ibsk;   // {issue, stall, bubble, kill} before the edge
    logic [31:0] exp_pend;   // pending after the edge
    logic [31:0] exp_cnt;    // stall count after the edge
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_used;
  logic        rs2_used;
  logic [4:0]  rd;
  logic        reg_write;
  logic        ex_ready;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_reg;

  logic        issue1, stall1, bubble1, kill1;
  logic [31:0] pend1;
  logic [31:0] cnt1;
  logic        issue0, stall0, bubble0, kill0;
  logic [31:0] pend0;
  logic [1:0]  cnt0;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t tbl[22];

  // Bypass build, full-width counter.
  id_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_idValid(id_valid),
    .i_rs1(rs1), .i_rs2(rs2), .i_rs1Used(rs1_used), .i_rs2Used(rs2_used),
    .i_rd(rd), .i_regWrite(reg_write), .i_exReady(ex_ready), .i_flush(flush),
    .i_wbValid(wb_valid), .i_wbReg(wb_reg),
    .o_issue(issue1), .o_stall(stall1), .o_bubble(bubble1), .o_kill(kill1),
    .o_pending(pend1), .o_stallCnt(cnt1)
  );

  // No-bypass build with a 2-bit counter to reach saturation quickly.
  id_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(2)) dut_nb (
    .i_clk(clk), .i_reset_n(reset_n), .i_idValid(id_valid),
    .i_rs1(rs1), .i_rs2(rs2), .i_rs1Used(rs1_used), .i_rs2Used(rs2_used),
    .i_rd(rd), .i_regWrite(reg_write), .i_exReady(ex_ready), .i_flush(flush),
    .i_wbValid(wb_valid), .i_wbReg(wb_reg),
    .o_issue(issue0), .o_stall(stall0), .o_bubble(bubble0), .o_kill(kill0),
    .o_pending(pend0), .o_stallCnt(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int v, input int r1, input int u1, input int r2, input int u2,
                              input int d, input int w, input int rdy, input int fl,
                              input int wbv, input int wbr, input logic [3:0] ibsk,
                              input logic [31:0] pend, input logic [31:0] cnt);
    vec_t t;
    t.v = 1'(v); t.rs1 = 5'(r1); t.u1 = 1'(u1); t.rs2 = 5'(r2); t.u2 = 1'(u2);
    t.rd = 5'(d); t.w = 1'(w); t.rdy = 1'(rdy); t.fl = 1'(fl);
    t.wbv = 1'(wbv); t.wbr = 5'(wbr);
    t.exp_ibsk = ibsk; t.exp_pend = pend; t.exp_cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; rs1 = t.rs1; rs1_used = t.u1; rs2 = t.rs2; rs2_used = t.u2;
    rd = t.rd; reg_write = t.w; ex_ready = t.rdy; flush = t.fl;
    wb_valid = t.wbv; wb_reg = t.wbr;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 32'h0, 32'h0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();

    // Main sequence (bypass build): each row is one cycle.
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0010, 32'h00, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 4'b1000, 32'h20, 0);
    tbl[2]  = mk(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0110, 32'h20, 1);
    tbl[3]  = mk(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0110, 32'h20, 2);
    tbl[4]  = mk(1, 5, 1, 0, 0, 0, 0, 1, 0, 1, 5, 4'b1000, 32'h00, 2);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4'b1000, 32'h00, 2);
    tbl[6]  = mk(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 4'b1000, 32'h00, 2);
    tbl[7]  = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 4'b1000, 32'h80, 2);
    tbl[8]  = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 7, 4'b1000, 32'h80, 2);
    tbl[9]  = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 4'b0110, 32'h80, 3);
    tbl[10] = mk(1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 0, 4'b0011, 32'h80, 3);
    tbl[11] = mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 4'b0011, 32'h80, 3);
    tbl[12] = mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 4'b1000, 32'h88, 3);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 9, 4'b0010, 32'h88, 3);
    tbl[14] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 4'b0110, 32'h88, 4);
    tbl[15] = mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 4'b1000, 32'h98, 4);
    tbl[16] = mk(1, 0, 0, 4, 1, 0, 0, 1, 1, 1, 3, 4'b0011, 32'h90, 4);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0011, 32'h90, 4);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0011, 32'h90, 4);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0010, 32'h90, 4);
    tbl[20] = mk(1, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 4'b0110, 32'h90, 5);
    tbl[21] = mk(1, 0, 0, 4, 1, 0, 0, 1, 0, 1, 4, 4'b1000, 32'h80, 5);

    // Reset state: issue follows idValid, nothing pending, no kill.
    do_reset();
    drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 32'h0, 32'h0));
    #1;
    chk("rst_pending", pend1, 32'h0);
    chk("rst_cnt", cnt1, 32'h0);
    chk("rst_kill", {31'd0, kill1}, 32'h0);
    chk("rst_issue", {31'd0, issue1}, 32'h1);
    idle();
    #1;
    chk("rst_issue_idle", {31'd0, issue1}, 32'h0);
    do_reset();

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d_ibsk", i), {28'd0, issue1, stall1, bubble1, kill1}, {28'd0, tbl[i].exp_ibsk});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_pend", i), pend1, tbl[i].exp_pend);
      chk($sformatf("row%0d_cnt", i), cnt1, tbl[i].exp_cnt);
    end

    // Reset in the middle of a RAW stall on r7 clears everything.
    @(negedge clk);
    drive(mk(1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 32'h0, 32'h0));
    #1;
    chk("midrst_stall_before", {31'd0, stall1}, 32'h1);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst_pending", pend1, 32'h0);
    chk("midrst_cnt", cnt1, 32'h0);
    chk("midrst_issue", {31'd0, issue1}, 32'h1);
    chk("midrst_kill", {31'd0, kill1}, 32'h0);

    // Bypass vs no-bypass retirement latency, then 2-bit counter saturation.
    do_reset();
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 4'b0000, 32'h0, 32'h0));
    @(posedge clk); #1;
    chk("nb_pend_set", pend0, 32'h20);
    @(negedge clk);
    drive(mk(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 32'h0, 32'h0));
    #1;
    chk("nb_stall_raw", {31'd0, stall0}, 32'h1);
    chk("bp_stall_raw", {31'd0, stall1}, 32'h1);
    @(negedge clk);
    drive(mk(1, 5, 1, 0, 0, 0, 0, 1, 0, 1, 5, 4'b0000, 32'h0, 32'h0));
    #1;
    chk("bp_issue_wb_cycle", {31'd0, issue1}, 32'h1);
    chk("nb_stall_wb_cycle", {31'd0, stall0}, 32'h1);
    @(posedge clk); #1;
    chk("nb_pend_cleared", pend0, 32'h0);
    chk("nb_cnt_two", {30'd0, cnt0}, 32'h2);
    chk("bp_cnt_one", cnt1, 32'h1);
    @(negedge clk);
    drive(mk(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 32'h0, 32'h0));
    #1;
    chk("nb_issue_next", {31'd0, issue0}, 32'h1);
    chk("nb_bubble_next", {31'd0, bubble0}, 32'h0);
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0));
    repeat (3) @(posedge clk);
    #1;
    chk("nb_cnt_saturated", {30'd0, cnt0}, 32'h3);
    chk("bp_cnt_four", cnt1, 32'h4);
    chk("bp_pend_no_set_bp", pend1, 32'h0);
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 32'h0, 32'h0));
    #1;
    chk("bp_single_issue", {31'd0, issue1}, 32'h1);
    @(posedge clk); #1;
    chk("nb_cnt_held", {30'd0, cnt0}, 32'h3);
    chk("bp_cnt_held", cnt1, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
